seq_mult8x8_nibble: RTL

- Sequential 8x8 unsigned multiplier built around the existing combinational 4x4 array multiplier core.
- Feeds the core one nibble pair per cycle over 4 cycles, and accumulates each shifted 8-bit partial product into a 16-bit result.
- Sits directly upstream and downstream of the core: drives its A/B inputs and consumes its P output.
- Presents a valid/ready handshake on both the operand side and the result side.

---
 rtl/seq_mult8x8_nibble_if.sv | 24 ++
 rtl/seq_mult8x8_nibble.sv | 99 +++++++++
 2 files changed

// File: rtl/seq_mult8x8_nibble_if.sv
// Operand/result handshake and 4x4 core hookup for seq_mult8x8_nibble.
// The multiplier itself uses the slave side; its environment uses the master side.
interface seq_mult8x8_nibble_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;

    modport slave (
        input  in_valid, a, b, out_ready, mul_p,
        output in_ready, out_valid, p, mul_a, mul_b
    );

    modport master (
        output in_valid, a, b, out_ready, mul_p,
        input  in_ready, out_valid, p, mul_a, mul_b
    );
endinterface

// File: rtl/seq_mult8x8_nibble.sv
// Sequential 8x8 unsigned multiplier driving an external 4x4 core,
// one nibble pair per cycle over four cycles.
module seq_mult8x8_nibble (
    input logic                 clk,
    input logic                 rst_n,
    seq_mult8x8_nibble_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  k;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [15:0] term;
    logic [15:0] acc_nx;
    logic [15:0] p_q;
    logic        out_valid_q;
    logic        accept;

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.mul_a = (state == MUL) ? (k[0] ? a_q[7:4] : a_q[3:0]) : 4'h0;
    assign bus.mul_b = (state == MUL) ? (k[1] ? b_q[7:4] : b_q[3:0]) : 4'h0;

    // Partial product weight: 0, 4, 4, 8 bits for steps 0..3
    always_comb begin
        term = 16'h0000;
        unique case (k)
            2'd0:    term = {8'h00, bus.mul_p};
            2'd1,
            2'd2:    term = {4'h0, bus.mul_p, 4'h0};
            2'd3:    term = {bus.mul_p, 8'h00};
            default: term = 16'h0000;
        endcase
    end

    assign acc_nx = acc + term;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = MUL;
            MUL:     if (k == 2'd3) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k           <= 2'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc         <= 16'h0000;
            p_q         <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                        acc <= 16'h0000;
                        k   <= 2'd0;
                    end
                end
                MUL: begin
                    acc <= acc_nx;
                    k   <= k + 2'd1;
                    // Publish the final sum on the same edge that enters DONE
                    if (k == 2'd3) begin
                        p_q         <= acc_nx;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
